ws2812_frame_sched: RTL and testbench
=====================================

// Module: ws2812_frame_sched
// PURPOSE
// - Frame scheduler between the rainbowReg colour pattern (96-bit frame) and the WS2812B bit serializer.
// - On each frame request it snapshots the frame and issues one 24-bit pixel word at a time over a valid/ready handshake.
// - After the last pixel it enforces the WS2812B latch/reset gap before it accepts the next frame.
// PARAMETERS
// - NUM_LEDS      4     pixels per frame; frameIn width is 24*NUM_LEDS
// - LATCH_CYCLES  6000  idle clk cycles after last pixel (60 us at 100 MHz; must be >= 2)
// PORTS
// - clk         in   1        100 MHz system clock; all logic on rising edge
// - reset       in   1        synchronous, active-high reset
// - pixelData   out  24       current pixel word, GRB, MSB first to serializer
// - pixelValid  out  1        pixelData is valid; held until accepted
// - busy        out  1        high in SEND or LATCH
// - frameDone   out  1        one-cycle pulse when the latch gap completes
// - overrun     out  1        one-cycle pulse when a frame request is dropped
// - frameIn     in   24*NUM_LEDS  frame from rainbowReg; LED0 = bits [24*NUM_LEDS-1 -: 24]
// - tenHzIn     in   1        frame request; one-cycle pulse expected, level sampled each clk
// - pixelReady  in   1        serializer accepts pixelData when pixelValid && pixelReady
// - brightShift in   3        channel attenuation, present only with WS2812_BRIGHT_EN
// BEHAVIOUR
// - Reset: state=IDLE, pixelData=0, pixelValid=0, busy=0, frameDone=0, overrun=0, pending=0, index=0, latch counter=0.
// - Reset mid-frame aborts immediately; no partial pixel is held; the next frame restarts at LED0.
// - States: IDLE, SEND, LATCH.
// - IDLE: if tenHzIn or pending is sampled high:
//   - latch frameIn into the shadow register;
//   - index=0, pending=0, go to SEND;
//   - pixelValid=1 with LED0 on the following cycle (1-cycle latency from request to first valid).
// - SEND: pixelData and pixelValid stay stable while pixelReady=0.
//   - On the accept cycle (valid&&ready), index increments.
//   - If the accepted pixel was not the last: next pixel is driven the next cycle, pixelValid stays 1 (no bubble).
//   - If it was the last (index=NUM_LEDS-1): pixelValid=0 next cycle, counter=LATCH_CYCLES-1, go to LATCH.
// - LATCH: counter decrements each cycle. At 0: go to IDLE and pulse frameDone for exactly one cycle.
//   - Gap from the last accept to frameDone = LATCH_CYCLES cycles.
// - Frame snapshot: frameIn changes during SEND/LATCH have no effect on the frame in progress.
// - Request while busy: set pending; it is serviced on the first IDLE cycle.
//   - Back-to-back frames are therefore separated by only the latch gap plus 1 cycle.
// - Request while busy and pending=1: dropped; overrun pulses 1 cycle; pending stays 1.
// - Request sampled in the same cycle LATCH reaches 0: sets pending; no overrun if pending was 0.
// - index width = clog2(NUM_LEDS), minimum 1; counter width = clog2(LATCH_CYCLES).
// - pixelReady while pixelValid=0 is ignored.
// CONFIGURATION
// - WS2812_BRIGHT_EN defined:
//   - each 8-bit channel of pixelData = channel >> brightShift (logical shift; 7 leaves 0 or 1);
//   - brightShift is sampled with the frame in IDLE and is constant for the whole frame.
// - WS2812_BRIGHT_EN undefined:
//   - brightShift port absent; pixelData = raw shadow pixel; no other behaviour changes.
// TESTING
// - Reset for 3 clk, pixelReady=1, frameIn=96'h0000FF_00FF00_FF0000_FFFFFF, one tenHzIn pulse:
//   - pixelValid rises 1 cycle after the pulse;
//   - words 0000FF, 00FF00, FF0000, FFFFFF on 4 consecutive cycles;
//   - frameDone 6000 cycles after the last accept.
// - pixelReady toggled 1-of-3 cycles during a frame: each word is held stable until accepted; order and count (4) unchanged.
// - Second tenHzIn during SEND: the new frame starts 1 cycle after frameDone.
//   - Third tenHzIn during the same frame: overrun pulses once and only two frames are sent.
// - frameIn changed to all-zero mid-SEND: the remaining words still come from the snapshot.
// - reset asserted after 2 accepts: all outputs 0 next cycle.
//   - A following tenHzIn restarts at LED0.
// - WS2812_BRIGHT_EN defined, brightShift=2, pixel FFFFFF -> 3F3F3F; pixel 010203 -> 000000.

Source files
------------

// File: rtl/ws2812_frame_sched_if.sv
// Pixel-word valid/ready handshake between the frame scheduler (master)
// and the WS2812B bit serializer (slave).
interface ws2812_frame_sched_if;
  logic [23:0] pixelData;
  logic        pixelValid;
  logic        pixelReady;

  modport master (output pixelData, output pixelValid, input pixelReady);
  modport slave  (input pixelData, input pixelValid, output pixelReady);
endinterface

// File: rtl/ws2812_frame_sched.sv
// WS2812B frame scheduler: snapshots a frame, streams it one GRB word at a time,
// then holds off for the latch gap. Define WS2812_BRIGHT_EN for per-channel attenuation.
//
// state | meaning
// IDLE  | waiting for tenHzIn or a pending request
// SEND  | streaming shadow pixels over the valid/ready handshake
// LATCH | counting down the WS2812B reset gap after the last pixel
module ws2812_frame_sched #(
  parameter int NUM_LEDS     = 4,
  parameter int LATCH_CYCLES = 6000
) (
  input  logic                      clk,
  input  logic                      reset,
  ws2812_frame_sched_if.master      pix,
  input  logic [24*NUM_LEDS-1:0]    frameIn,
  input  logic                      tenHzIn,
`ifdef WS2812_BRIGHT_EN
  input  logic [2:0]                brightShift,
`endif
  output logic                      busy,
  output logic                      frameDone,
  output logic                      overrun
);

  localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int CNT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);

  typedef enum logic [1:0] {IDLE, SEND, LATCH} stateT;

  stateT                   state, stateNext;
  logic [24*NUM_LEDS-1:0]  shadow, shadowNext;
  logic [IDX_W-1:0]        index, indexNext, nextIdx;
  logic [CNT_W-1:0]        counter, counterNext;
  logic                    pending, pendingNext;
  logic [23:0]             dataNext, firstWord, followWord;
  logic                    validNext, doneNext, overrunNext, accept;

  function automatic logic [23:0] pixelAt(input logic [24*NUM_LEDS-1:0] frame, input int idx);
    logic [24*NUM_LEDS-1:0] shifted;
    shifted = frame << (24 * idx);
    return shifted[24*NUM_LEDS-1 -: 24];
  endfunction

  assign accept  = pix.pixelValid && pix.pixelReady;
  assign nextIdx = (index == LAST_IDX) ? index : index + IDX_W'(1);
  assign busy    = (state != IDLE);

`ifdef WS2812_BRIGHT_EN
  logic [2:0] shiftReg, shiftNext;

  function automatic logic [23:0] attenuate(input logic [23:0] w, input logic [2:0] s);
    return {w[23:16] >> s, w[15:8] >> s, w[7:0] >> s};
  endfunction

  // First word uses the live shift; the rest use the value captured with the frame.
  assign firstWord  = attenuate(frameIn[24*NUM_LEDS-1 -: 24], brightShift);
  assign followWord = attenuate(pixelAt(shadow, int'(nextIdx)), shiftReg);
`else
  assign firstWord  = frameIn[24*NUM_LEDS-1 -: 24];
  assign followWord = pixelAt(shadow, int'(nextIdx));
`endif

  always_comb begin
    stateNext   = state;
    shadowNext  = shadow;
    indexNext   = index;
    counterNext = counter;
    pendingNext = pending;
    dataNext    = pix.pixelData;
    validNext   = pix.pixelValid;
    doneNext    = 1'b0;
    overrunNext = 1'b0;
`ifdef WS2812_BRIGHT_EN
    shiftNext   = shiftReg;
`endif
    case (state)
      IDLE: begin
        if (tenHzIn || pending) begin
          shadowNext  = frameIn;
          indexNext   = '0;
          pendingNext = 1'b0;
          dataNext    = firstWord;
          validNext   = 1'b1;
          stateNext   = SEND;
`ifdef WS2812_BRIGHT_EN
          shiftNext   = brightShift;
`endif
        end
      end
      SEND: begin
        if (accept) begin
          if (index == LAST_IDX) begin
            validNext   = 1'b0;
            counterNext = CNT_W'(LATCH_CYCLES - 1);
            stateNext   = LATCH;
          end else begin
            indexNext = nextIdx;
            dataNext  = followWord;
          end
        end
      end
      LATCH: begin
        // Leaving on the 1->0 step puts frameDone exactly LATCH_CYCLES after the last accept.
        if (counter <= CNT_W'(1)) begin
          counterNext = '0;
          doneNext    = 1'b1;
          stateNext   = IDLE;
        end else begin
          counterNext = counter - CNT_W'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
    if (state != IDLE && tenHzIn) begin
      if (pending) overrunNext = 1'b1;
      else         pendingNext = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      shadow         <= '0;
      index          <= '0;
      counter        <= '0;
      pending        <= 1'b0;
      pix.pixelData  <= '0;
      pix.pixelValid <= 1'b0;
      frameDone      <= 1'b0;
      overrun        <= 1'b0;
`ifdef WS2812_BRIGHT_EN
      shiftReg       <= '0;
`endif
    end else begin
      state          <= stateNext;
      shadow         <= shadowNext;
      index          <= indexNext;
      counter        <= counterNext;
      pending        <= pendingNext;
      pix.pixelData  <= dataNext;
      pix.pixelValid <= validNext;
      frameDone      <= doneNext;
      overrun        <= overrunNext;
`ifdef WS2812_BRIGHT_EN
      shiftReg       <= shiftNext;
`endif
    end
  end

endmodule

// File: tb/tb_ws2812_frame_sched.sv
// Bench for ws2812_frame_sched: queue-based frame model checked every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_ws2812_frame_sched;
  localparam int N = 4;
  localparam int L = 6000;
  localparam logic [95:0] PAT = 96'h0000FF_00FF00_FF0000_FFFFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tenHzIn = 1'b0;
  logic [95:0] frameIn = '0;
  logic        busy, frameDone, overrun;
`ifdef WS2812_BRIGHT_EN
  logic [2:0]  brightShift = 3'd0;
`endif

  ws2812_frame_sched_if pix();

  ws2812_frame_sched #(.NUM_LEDS(N), .LATCH_CYCLES(L)) dut (
    .clk(clk),
    .reset(reset),
    .pix(pix),
    .frameIn(frameIn),
    .tenHzIn(tenHzIn),
`ifdef WS2812_BRIGHT_EN
    .brightShift(brightShift),
`endif
    .busy(busy),
    .frameDone(frameDone),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cntAcc = 0, cntOver = 0, cntDone = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: words still to be shown, cycles left in the latch gap, one pending slot.
  logic [23:0] q[$];
  int          gap = 0;
  bit          pend = 0, expDone = 0, expOver = 0, expZero = 0, live = 0;

  function automatic logic [23:0] scale(input logic [23:0] w, input int s);
    int g, r, b;
    g = int'(w[23:16]) / (1 << s);
    r = int'(w[15:8])  / (1 << s);
    b = int'(w[7:0])   / (1 << s);
    return 24'(g * 65536 + r * 256 + b);
  endfunction

  always @(negedge clk) begin
    bit acc, busyNow;
    int sh;
    if (live) begin
      chk("pixelValid", pix.pixelValid, q.size() > 0);
      chk("busy", busy, (q.size() > 0) || (gap > 0));
      chk("frameDone", frameDone, expDone);
      chk("overrun", overrun, expOver);
      if (q.size() > 0) chk("pixelData", pix.pixelData, q[0]);
      else if (expZero) chk("pixelDataReset", pix.pixelData, 0);
    end
    if (pix.pixelValid === 1'b1 && pix.pixelReady === 1'b1) cntAcc++;
    if (overrun === 1'b1) cntOver++;
    if (frameDone === 1'b1) cntDone++;

    acc     = (q.size() > 0) && pix.pixelReady;
    busyNow = (q.size() > 0) || (gap > 0);
    expDone = 0;
    expOver = 0;
`ifdef WS2812_BRIGHT_EN
    sh = int'(brightShift);
`else
    sh = 0;
`endif
    if (reset) begin
      q.delete();
      gap = 0; pend = 0; expZero = 1; live = 1;
    end else begin
      if (busyNow && tenHzIn) begin
        if (pend) expOver = 1;
        else      pend = 1;
      end
      if (q.size() > 0) begin
        if (acc) begin
          void'(q.pop_front());
          if (q.size() == 0) gap = L - 1;
        end
      end else if (gap > 0) begin
        gap--;
        if (gap == 0) expDone = 1;
      end else if (tenHzIn || pend) begin
        for (int i = 0; i < N; i++) q.push_back(scale(24'(frameIn >> (24 * (N - 1 - i))), sh));
        pend = 0;
        expZero = 0;
      end
    end
  end

  task tick;
    @(posedge clk);
    #1;
  endtask

  // Called in the last-accept cycle; returns cycles until frameDone is seen.
  task waitDone(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (frameDone !== 1'b1 && n < L + 200);
  endtask

  initial begin
    int n, a0, o0, d0;
    pix.pixelReady = 1'b1;
    frameIn = PAT;
    reset = 1'b1;
    repeat (3) tick();
    chk("reset_valid", pix.pixelValid, 0);
    chk("reset_data", pix.pixelData, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", frameDone, 0);
    chk("reset_overrun", overrun, 0);
    reset = 1'b0;
    tick();

    // Basic frame with ready held high
    tenHzIn = 1'b1; tick(); tenHzIn = 1'b0;
    chk("t1_latency_valid", pix.pixelValid, 1);
    chk("t1_word0", pix.pixelData, 24'h0000FF); tick();
    chk("t1_word1", pix.pixelData, 24'h00FF00); tick();
    chk("t1_word2", pix.pixelData, 24'hFF0000); tick();
    chk("t1_word3", pix.pixelData, 24'hFFFFFF);
    waitDone(n);
    chk("t1_latch_gap", n, L);
    tick();

    // Ready asserted one cycle in three
    a0 = cntAcc;
    pix.pixelReady = 1'b0;
    tenHzIn = 1'b1; tick(); tenHzIn = 1'b0;
    for (int i = 0; i < 60; i++) begin
      pix.pixelReady = (i % 3 == 2);
      tick();
    end
    pix.pixelReady = 1'b1;
    waitDone(n);
    chk("t2_accept_count", cntAcc - a0, 4);
    tick();

    // Second request pends, third overruns
    a0 = cntAcc; o0 = cntOver; d0 = cntDone;
    pix.pixelReady = 1'b0;
    tenHzIn = 1'b1; tick();
    tick();
    tenHzIn = 1'b0; tick();
    tenHzIn = 1'b1; tick();
    tenHzIn = 1'b0; tick();
    pix.pixelReady = 1'b1;
    waitDone(n);
    tick();
    chk("t3_restart_after_done", pix.pixelValid, 1);
    chk("t3_restart_word0", pix.pixelData, 24'h0000FF);
    waitDone(n);
    tick(); tick();
    chk("t3_overruns", cntOver - o0, 1);
    chk("t3_accepts", cntAcc - a0, 8);
    chk("t3_frames", cntDone - d0, 2);

    // frameIn cleared mid-send
    tenHzIn = 1'b1; tick(); tenHzIn = 1'b0;
    tick();
    frameIn = '0;
    tick();
    chk("t4_snapshot_word2", pix.pixelData, 24'hFF0000); tick();
    chk("t4_snapshot_word3", pix.pixelData, 24'hFFFFFF);
    waitDone(n);
    tick();

    // Reset after two accepts, then restart at LED0
    frameIn = PAT;
    tenHzIn = 1'b1; tick(); tenHzIn = 1'b0;
    tick(); tick();
    reset = 1'b1; tick();
    chk("t5_valid", pix.pixelValid, 0);
    chk("t5_data", pix.pixelData, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", frameDone, 0);
    chk("t5_overrun", overrun, 0);
    reset = 1'b0;
    tenHzIn = 1'b1; tick(); tenHzIn = 1'b0;
    chk("t5_restart_valid", pix.pixelValid, 1);
    chk("t5_restart_word0", pix.pixelData, 24'h0000FF);
    tick(); tick(); tick();
    waitDone(n);
    tick();

`ifdef WS2812_BRIGHT_EN
    brightShift = 3'd2;
    frameIn = 96'hFFFFFF_010203_000000_808080;
    tenHzIn = 1'b1; tick(); tenHzIn = 1'b0;
    brightShift = 3'd0;
    chk("br_word0", pix.pixelData, 24'h3F3F3F); tick();
    chk("br_word1", pix.pixelData, 24'h000000); tick();
    tick();
    chk("br_word3", pix.pixelData, 24'h202020);
    waitDone(n);
    tick();
`endif

    // Randomized phase
    for (int i = 0; i < 30000; i++) begin
      pix.pixelReady = 1'($urandom_range(0, 1));
      tenHzIn = ($urandom_range(0, 1999) == 0);
      if ($urandom_range(0, 7) == 0) frameIn = {$urandom, $urandom, $urandom};
      reset = ($urandom_range(0, 19999) == 0);
`ifdef WS2812_BRIGHT_EN
      if ($urandom_range(0, 15) == 0) brightShift = 3'($urandom_range(0, 7));
`endif
      tick();
    end
    reset = 1'b0;
    tenHzIn = 1'b0;
    pix.pixelReady = 1'b1;
    n = 0;
    while ((busy !== 1'b0 || pix.pixelValid !== 1'b0) && n < 3 * L) begin
      tick();
      n++;
    end
    chk("drain_idle", busy, 0);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
